// File: rtl/ram_port_arbiter.sv
// Arbiter/sequencer sharing a single-ported RAM between instruction fetch and load/store.
// Optional starvation guard for the fetch port: define ARB_STARVE_GUARD_EN.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              F_REQ,
  input  logic [ADDR_W-1:0] F_ADDR,
  output logic              F_GNT,
  output logic              F_RVALID,
  output logic [DATA_W-1:0] F_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              D_WACK,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_RW,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              BUSY
);

  typedef enum logic [2:0] {IDLE, READ, WSETUP, WPULSE, WHOLD} state_e;

  state_e              state_q, state_d;
  logic                rd_is_d_q, rd_is_d_d;
  logic                f_gnt_q, f_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                f_rvalid_q, f_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic                d_wack_q, d_wack_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_d, grant_f;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  // Fetch takes the slot once data has won LIMIT4 times in a row over a waiting fetch.
  assign grant_d = D_REQ && !(F_REQ && (starve_q == LIMIT4));

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (grant_f)
        starve_d = '0;
      else if (grant_d && F_REQ && (starve_q != LIMIT4))
        starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign grant_d = D_REQ;
`endif

  assign grant_f = F_REQ && !grant_d;

  always_comb begin
    state_d     = state_q;
    rd_is_d_d   = rd_is_d_q;
    f_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    f_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    d_wack_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          d_gnt_d    = 1'b1;
          ram_addr_d = D_ADDR;
          if (D_WE) begin
            ram_wdata_d = D_WDATA;
            state_d     = WSETUP;
          end else begin
            rd_is_d_d = 1'b1;
            state_d   = READ;
          end
        end else if (grant_f) begin
          f_gnt_d    = 1'b1;
          ram_addr_d = F_ADDR;
          rd_is_d_d  = 1'b0;
          state_d    = READ;
        end
      end
      READ: begin
        if (rd_is_d_q) begin
          d_rdata_d  = RAM_RDATA;
          d_rvalid_d = 1'b1;
        end else begin
          f_rdata_d  = RAM_RDATA;
          f_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      WSETUP: state_d = WPULSE;
      WPULSE: state_d = WHOLD;
      WHOLD: begin
        d_wack_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      rd_is_d_q   <= 1'b0;
      f_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      f_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_wack_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_is_d_q   <= rd_is_d_d;
      f_gnt_q     <= f_gnt_d;
      d_gnt_q     <= d_gnt_d;
      f_rvalid_q  <= f_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      d_wack_q    <= d_wack_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // RW is a pure decode of the state flop so an async reset drops it immediately.
  assign RAM_RW    = (state_q == WPULSE);
  assign BUSY      = (state_q != IDLE);
  assign F_GNT     = f_gnt_q;
  assign D_GNT     = d_gnt_q;
  assign F_RVALID  = f_rvalid_q;
  assign D_RVALID  = d_rvalid_q;
  assign D_WACK    = d_wack_q;
  assign F_RDATA   = f_rdata_q;
  assign D_RDATA   = d_rdata_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, table-driven bench for ram_port_arbiter with a behavioural 64K x 32 RAM.
module tb_ram_port_arbiter;

  logic        CLK, RESET;
  logic        F_REQ, F_GNT, F_RVALID;
  logic [15:0] F_ADDR;
  logic [31:0] F_RDATA;
  logic        D_REQ, D_WE, D_GNT, D_RVALID, D_WACK;
  logic [15:0] D_ADDR;
  logic [31:0] D_WDATA, D_RDATA;
  logic [15:0] RAM_ADDR;
  logic [31:0] RAM_WDATA, RAM_RDATA;
  logic        RAM_RW, BUSY;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_GNT(F_GNT), .F_RVALID(F_RVALID), .F_RDATA(F_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_GNT(D_GNT),
    .D_RVALID(D_RVALID), .D_RDATA(D_RDATA), .D_WACK(D_WACK),
    .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_RW(RAM_RW), .RAM_RDATA(RAM_RDATA),
    .BUSY(BUSY)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] mem [0:65535];
  bit          preload_done = 1'b0;
  assign RAM_RDATA = mem[RAM_ADDR];

  always @(posedge CLK) begin
    if (!preload_done) begin
      mem[16'h0004] <= 32'hDEADBEEF;
      mem[16'h0200] <= 32'h11111111;
      preload_done  <= 1'b1;
    end else if (RAM_RW) begin
      mem[RAM_ADDR] <= RAM_WDATA;
    end
  end

  logic rw_prev = 1'b0;
  int   rw_consec = 0;
  always @(negedge CLK) begin
    if (rw_prev && RAM_RW) rw_consec <= rw_consec + 1;
    rw_prev <= RAM_RW;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_f_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      D_REQ = 1'b1; D_WE = v.we; D_ADDR = v.addr; D_WDATA = v.wdata;
    end else begin
      F_REQ = 1'b1; F_ADDR = v.addr;
    end
    tick();
    chk("gnt_d", 32'(D_GNT), 32'(v.is_d));
    chk("gnt_f", 32'(F_GNT), 32'(!v.is_d));
    chk("busy_gnt", 32'(BUSY), 32'd1);
    chk("rw_first", 32'(RAM_RW), 32'd0);
    chk("addr_gnt", 32'(RAM_ADDR), 32'(v.addr));
    D_REQ = 1'b0; F_REQ = 1'b0;
    if (v.is_d && v.we) begin
      chk("wdata_setup", RAM_WDATA, v.wdata);
      tick();
      chk("rw_pulse", 32'(RAM_RW), 32'd1);
      chk("addr_pulse", 32'(RAM_ADDR), 32'(v.addr));
      chk("wdata_pulse", RAM_WDATA, v.wdata);
      tick();
      chk("rw_hold", 32'(RAM_RW), 32'd0);
      chk("addr_hold", 32'(RAM_ADDR), 32'(v.addr));
      chk("wdata_hold", RAM_WDATA, v.wdata);
      chk("busy_hold", 32'(BUSY), 32'd1);
      tick();
      chk("wack", 32'(D_WACK), 32'd1);
      chk("busy_wack", 32'(BUSY), 32'd0);
      chk("d_rvalid_wr", 32'(D_RVALID), 32'd0);
    end else begin
      tick();
      if (v.is_d) exp_d_rdata = v.exp;
      else        exp_f_rdata = v.exp;
      chk("d_rvalid", 32'(D_RVALID), 32'(v.is_d));
      chk("f_rvalid", 32'(F_RVALID), 32'(!v.is_d));
      chk("d_rdata", D_RDATA, exp_d_rdata);
      chk("f_rdata", F_RDATA, exp_f_rdata);
      chk("rw_read", 32'(RAM_RW), 32'd0);
      chk("busy_rvalid", 32'(BUSY), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0004, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 16'h0100, 32'h12345678, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 16'h0100, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 32'hA5A5A5A5, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{1'b1, 1'b0, 16'h0004, 32'h0,        32'hDEADBEEF};

    RESET = 1'b0; F_REQ = 1'b0; F_ADDR = '0;
    D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_rw", 32'(RAM_RW), 32'd0);
    chk("rst_addr", 32'(RAM_ADDR), 32'd0);
    chk("rst_wdata", RAM_WDATA, 32'd0);
    chk("rst_frdata", F_RDATA, 32'd0);
    chk("rst_drdata", D_RDATA, 32'd0);
    chk("rst_pulses", {26'd0, F_GNT, D_GNT, F_RVALID, D_RVALID, D_WACK, BUSY}, 32'd0);
    RESET = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Simultaneous requests: data read first, fetch at the next IDLE.
    F_REQ = 1'b1; F_ADDR = 16'h0004;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h0100;
    tick();
    chk("sim_d_gnt", 32'(D_GNT), 32'd1);
    chk("sim_f_gnt0", 32'(F_GNT), 32'd0);
    D_REQ = 1'b0;
    tick();
    chk("sim_d_rvalid", 32'(D_RVALID), 32'd1);
    chk("sim_d_rdata", D_RDATA, 32'h12345678);
    chk("sim_f_gnt1", 32'(F_GNT), 32'd0);
    tick();
    chk("sim_f_gnt", 32'(F_GNT), 32'd1);
    F_REQ = 1'b0;
    tick();
    chk("sim_f_rvalid", 32'(F_RVALID), 32'd1);
    chk("sim_f_rdata", F_RDATA, 32'hDEADBEEF);
    exp_d_rdata = 32'h12345678;
    exp_f_rdata = 32'hDEADBEEF;

    // Both held: guard build yields D,D,D,F repeating; default never grants F.
    F_REQ = 1'b1; F_ADDR = 16'h0004;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h0100;
    for (int i = 1; i <= 16; i++) begin
      bit ef;
      tick();
      if (i % 2 == 1) begin
        ef = GUARD && (((i - 1) / 2) % 4 == 3);
        chk("starve_d_gnt", 32'(D_GNT), 32'(!ef));
        chk("starve_f_gnt", 32'(F_GNT), 32'(ef));
      end
    end
    F_REQ = 1'b0; D_REQ = 1'b0;
    tick();
    chk("starve_idle", 32'(BUSY), 32'd0);

    // Back-to-back writes with D_REQ held: grant every 4 cycles, WACK 3 cycles later.
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h0300; D_WDATA = 32'hC0DE0001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("b2b_gnt", 32'(D_GNT), 32'(i % 4 == 1));
      chk("b2b_wack", 32'(D_WACK), 32'(i % 4 == 0));
      if (i % 4 == 1) D_WDATA = 32'hC0DE0001 + 32'((i - 1) / 4 + 1);
      if (i == 9) D_REQ = 1'b0;
    end
    chk("b2b_word", mem[16'h0300], 32'hC0DE0003);

    // Reset during WPULSE: RW must fall without a clock edge, nothing reaches the RAM.
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h0200; D_WDATA = 32'h22222222;
    tick();
    chk("abort_gnt", 32'(D_GNT), 32'd1);
    D_REQ = 1'b0;
    tick();
    chk("abort_pulse", 32'(RAM_RW), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("abort_rw", 32'(RAM_RW), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_addr", 32'(RAM_ADDR), 32'd0);
    chk("abort_wdata", RAM_WDATA, 32'd0);
    chk("abort_rdata", D_RDATA | F_RDATA, 32'd0);
    repeat (2) tick();
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_wack", 32'(D_WACK), 32'd0);
    end
    chk("abort_word", mem[16'h0200], 32'h11111111);
    exp_d_rdata = '0;
    exp_f_rdata = '0;
    begin
      vec_t v;
      v = '{1'b1, 1'b0, 16'h0200, 32'h0, 32'h11111111};
      run_vec(v);
    end

    tick();
    chk("rw_never_consecutive", 32'(rw_consec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
